// File: rtl/assert_mon_pkg.sv
// Shared constants, the failure-record type and saturating arithmetic helpers
// for the assertion event monitor.
package assert_mon_pkg;

    localparam int DEF_N_CHK      = 4;
    localparam int DEF_CW         = 8;
    localparam int DEF_TW         = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_IDXW       = (DEF_N_CHK > 1) ? $clog2(DEF_N_CHK) : 1;

    // Failure record for the default configuration; the top builds its own
    // record type from its actual parameters and hands it to the FIFO.
    typedef struct packed {
        logic [DEF_IDXW-1:0] idx;
        logic [DEF_TW-1:0]   tstamp;
    } fail_rec_t;

    // Add inc to val, clamping at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_add(input logic [31:0] val,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_v;
        max_v = (33'd1 << width) - 33'd1;
        sum   = {1'b0, val} + {1'b0, inc};
        if (sum > max_v) begin
            return max_v[31:0];
        end
        return sum[31:0];
    endfunction

    // Increment by one with saturation.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        return sat_add(val, 32'd1, width);
    endfunction

endpackage

// File: rtl/assert_evt_fifo.sv
// First-word fall-through FIFO for failure records. A push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module assert_evt_fifo
    import assert_mon_pkg::*;
#(
    parameter type rec_t      = fail_rec_t,
    parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  rec_t push_data_i,
    input  logic pop_i,
    output rec_t head_o,
    output logic full_o,
    output logic empty_o,
    output logic push_ok_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    rec_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            do_push;
    logic            do_pop;

    assign full_o    = (occ_q == OW'(FIFO_DEPTH));
    assign empty_o   = (occ_q == '0);
    assign do_pop    = pop_i & ~empty_o;
    assign do_push   = push_i & (~full_o | do_pop);
    assign push_ok_o = do_push;

    // Empty FIFO presents an all-zero head so idle outputs read as zero.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!do_push && do_pop) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Record storage; contents need no reset since empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/assert_event_monitor.sv
// Collects pass/fail strobes from assertion checkers: saturating per-checker
// counters, a sticky fail flag, a drop counter and a timestamped FIFO of
// failure records for a downstream logger.
module assert_event_monitor
    import assert_mon_pkg::*;
#(
    parameter int N_CHK      = DEF_N_CHK,
    parameter int CW         = DEF_CW,
    parameter int TW         = DEF_TW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int IDXW       = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             assert_on,
    input  logic [N_CHK-1:0] chk_mask,
    input  logic [N_CHK-1:0] chk_valid,
    input  logic [N_CHK-1:0] chk_pass,
    input  logic             clr_stats,
    input  logic [IDXW-1:0]  sel,
    output logic [CW-1:0]    pass_cnt_o,
    output logic [CW-1:0]    fail_cnt_o,
    output logic [CW-1:0]    drop_cnt,
    output logic             any_fail,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDXW-1:0]  evt_idx,
    output logic [TW-1:0]    evt_time
);

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [TW-1:0]   tstamp;
    } rec_t;

    logic [N_CHK-1:0] qual, qpass, qfail;
    logic [CW-1:0]    pass_cnt_q [N_CHK];
    logic [CW-1:0]    pass_cnt_d [N_CHK];
    logic [CW-1:0]    fail_cnt_q [N_CHK];
    logic [CW-1:0]    fail_cnt_d [N_CHK];
    logic [CW-1:0]    pass_rd_q, pass_rd_d;
    logic [CW-1:0]    fail_rd_q, fail_rd_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic             any_fail_q, any_fail_d;
    logic [TW-1:0]    ts_q, ts_d;
    logic [IDXW-1:0]  cand_idx;
    logic             cand_valid;
    logic [4:0]       n_fail;
    logic [31:0]      drop_inc;
    logic             fifo_full, fifo_empty, push_ok, pop;
    rec_t             cand_rec, head_rec;

    // Qualification and per-checker counter next-state.
    for (genvar gi = 0; gi < N_CHK; gi++) begin : g_chk
        assign qual[gi]  = chk_valid[gi] & assert_on & ~chk_mask[gi];
        assign qpass[gi] = qual[gi] & chk_pass[gi];
        assign qfail[gi] = qual[gi] & ~chk_pass[gi];

        assign pass_cnt_d[gi] = clr_stats ? '0 :
                                qpass[gi] ? CW'(sat_inc(32'(pass_cnt_q[gi]), CW)) :
                                pass_cnt_q[gi];
        assign fail_cnt_d[gi] = clr_stats ? '0 :
                                qfail[gi] ? CW'(sat_inc(32'(fail_cnt_q[gi]), CW)) :
                                fail_cnt_q[gi];
    end

    // Pick the lowest-index fail as push candidate and count all fails.
    always_comb begin
        cand_idx   = '0;
        cand_valid = 1'b0;
        n_fail     = '0;
        for (int i = N_CHK - 1; i >= 0; i--) begin
            if (qfail[i]) begin
                cand_idx   = IDXW'(i);
                cand_valid = 1'b1;
            end
        end
        for (int i = 0; i < N_CHK; i++) begin
            n_fail = n_fail + 5'(qfail[i]);
        end
    end

    assign pop             = evt_valid & evt_ready;
    assign cand_rec.idx    = cand_idx;
    assign cand_rec.tstamp = ts_q;

    // Extra same-cycle fails plus a candidate the FIFO could not take are lost.
    assign drop_inc = 32'(n_fail) - 32'(cand_valid) + 32'(cand_valid & ~push_ok);

    // Statistics, sticky flag and timestamp next-state; clear beats new events.
    always_comb begin
        drop_d     = clr_stats ? '0 : CW'(sat_add(32'(drop_q), drop_inc, CW));
        any_fail_d = clr_stats ? 1'b0 : (any_fail_q | cand_valid);
        ts_d       = ts_q + TW'(1);
    end

    // Registered readout mux; out-of-range select reads zero.
    always_comb begin
        pass_rd_d = '0;
        fail_rd_d = '0;
        for (int i = 0; i < N_CHK; i++) begin
            if (sel == IDXW'(i)) begin
                pass_rd_d = pass_cnt_q[i];
                fail_rd_d = fail_cnt_q[i];
            end
        end
    end

    // All monitor state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CHK; i++) begin
                pass_cnt_q[i] <= '0;
                fail_cnt_q[i] <= '0;
            end
            pass_rd_q  <= '0;
            fail_rd_q  <= '0;
            drop_q     <= '0;
            any_fail_q <= 1'b0;
            ts_q       <= '0;
        end else begin
            for (int i = 0; i < N_CHK; i++) begin
                pass_cnt_q[i] <= pass_cnt_d[i];
                fail_cnt_q[i] <= fail_cnt_d[i];
            end
            pass_rd_q  <= pass_rd_d;
            fail_rd_q  <= fail_rd_d;
            drop_q     <= drop_d;
            any_fail_q <= any_fail_d;
            ts_q       <= ts_d;
        end
    end

    assert_evt_fifo #(
        .rec_t      (rec_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (cand_valid),
        .push_data_i (cand_rec),
        .pop_i       (pop),
        .head_o      (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .push_ok_o   (push_ok)
    );

    assign evt_valid  = ~fifo_empty;
    assign evt_idx    = head_rec.idx;
    assign evt_time   = head_rec.tstamp;
    assign pass_cnt_o = pass_rd_q;
    assign fail_cnt_o = fail_rd_q;
    assign drop_cnt   = drop_q;
    assign any_fail   = any_fail_q;

endmodule

// File: tb/tb_assert_event_monitor.sv
// Directed plus randomized bench for assert_event_monitor, checked against a
// transaction-level model (integer counters and a queue of records).
module tb_assert_event_monitor;

    localparam int N     = 4;
    localparam int CMAX  = 255;
    localparam int DEPTH = 8;
    localparam int TMOD  = 65536;

    logic       clk = 1'b0;
    logic       rst;
    logic       assert_on;
    logic [3:0] chk_mask, chk_valid, chk_pass;
    logic       clr_stats;
    logic [1:0] sel;
    logic [7:0] pass_cnt_o, fail_cnt_o, drop_cnt;
    logic       any_fail, evt_valid, evt_ready;
    logic [1:0] evt_idx;
    logic [15:0] evt_time;

    always #5 clk = ~clk;

    assert_event_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .assert_on  (assert_on),
        .chk_mask   (chk_mask),
        .chk_valid  (chk_valid),
        .chk_pass   (chk_pass),
        .clr_stats  (clr_stats),
        .sel        (sel),
        .pass_cnt_o (pass_cnt_o),
        .fail_cnt_o (fail_cnt_o),
        .drop_cnt   (drop_cnt),
        .any_fail   (any_fail),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_idx    (evt_idx),
        .evt_time   (evt_time)
    );

    typedef struct {
        int idx;
        int t;
    } rec_t;

    // Reference model state.
    int   m_pass [N];
    int   m_fail [N];
    int   m_drop, m_any, m_ts, m_po, m_fo;
    rec_t m_q [$];

    int passes = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pass[i] = 0;
            m_fail[i] = 0;
        end
        m_drop = 0; m_any = 0; m_ts = 0; m_po = 0; m_fo = 0;
        m_q.delete();
    endtask

    task automatic check_all();
        chk("pass_cnt_o", 32'(pass_cnt_o), m_po);
        chk("fail_cnt_o", 32'(fail_cnt_o), m_fo);
        chk("drop_cnt",   32'(drop_cnt),   m_drop);
        chk("any_fail",   32'(any_fail),   m_any);
        chk("evt_valid",  32'(evt_valid),  (m_q.size() > 0) ? 1 : 0);
        chk("evt_idx",    32'(evt_idx),    (m_q.size() > 0) ? m_q[0].idx : 0);
        chk("evt_time",   32'(evt_time),   (m_q.size() > 0) ? m_q[0].t : 0);
        chk("ts",         32'(dut.ts_q),   m_ts);
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cyc(input logic a_on, input logic [3:0] msk, input logic [3:0] v,
                       input logic [3:0] p, input logic clr, input logic [1:0] s,
                       input logic rdy);
        int   cand, nfails, drops;
        bit   do_pop;
        rec_t r;
        assert_on = a_on; chk_mask = msk; chk_valid = v; chk_pass = p;
        clr_stats = clr; sel = s; evt_ready = rdy;

        m_po   = (int'(s) < N) ? m_pass[s] : 0;
        m_fo   = (int'(s) < N) ? m_fail[s] : 0;
        do_pop = (m_q.size() > 0) && rdy;
        cand   = -1;
        nfails = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && a_on && !msk[i]) begin
                if (p[i]) begin
                    if (!clr) m_pass[i] = (m_pass[i] < CMAX) ? m_pass[i] + 1 : CMAX;
                end else begin
                    if (!clr) m_fail[i] = (m_fail[i] < CMAX) ? m_fail[i] + 1 : CMAX;
                    nfails++;
                    if (cand < 0) cand = i;
                end
            end
        end
        drops = (nfails > 0) ? nfails - 1 : 0;
        if (do_pop) begin
            r = m_q.pop_front();
            $display("t=%0t pop record idx=%0d time=%0d", $time, r.idx, r.t);
        end
        if (cand >= 0) begin
            if (m_q.size() < DEPTH) begin
                r.idx = cand;
                r.t   = m_ts;
                m_q.push_back(r);
            end else begin
                drops++;
            end
        end
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                m_pass[i] = 0;
                m_fail[i] = 0;
            end
            m_drop = 0;
            m_any  = 0;
        end else begin
            m_drop = (m_drop + drops > CMAX) ? CMAX : m_drop + drops;
            if (nfails > 0) m_any = 1;
        end
        m_ts = (m_ts + 1) % TMOD;

        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input logic [1:0] s, input logic rdy);
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, s, rdy);
    endtask

    // Reset with garbage on the inputs, which must be ignored.
    task automatic do_reset();
        rst = 1'b1;
        assert_on = 1'b1; chk_mask = 4'h0; chk_valid = 4'hF; chk_pass = 4'h0;
        clr_stats = 1'b0; sel = 2'd1; evt_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        // Reset then idle: everything zero, timestamp counts from zero.
        do_reset();
        for (int i = 0; i < 5; i++) idle(2'd0, 1'b0);
        chk("ts_after_5_idle", 32'(dut.ts_q), 5);

        // Fail then pass on checker 1 at ts 10/11.
        while (m_ts != 10) idle(2'd1, 1'b0);
        cyc(1'b1, 4'h0, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
        cyc(1'b1, 4'h0, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
        chk("first_evt_valid", 32'(evt_valid), 1);
        chk("first_evt_idx",   32'(evt_idx),   1);
        chk("first_evt_time",  32'(evt_time),  10);
        idle(2'd1, 1'b0);
        chk("ts13_pass_cnt", 32'(pass_cnt_o), 1);
        chk("ts13_fail_cnt", 32'(fail_cnt_o), 1);
        chk("ts13_any_fail", 32'(any_fail),   1);
        idle(2'd1, 1'b1);

        // Global gate off, then a single qualified fail.
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 50; i++) cyc(1'b0, 4'h0, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b0);
        chk("gate_off_no_evt", 32'(evt_valid), 0);
        cyc(1'b1, 4'h0, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b0);
        idle(2'd0, 1'b0);
        chk("gate_fail_cnt0", 32'(fail_cnt_o), 1);
        idle(2'd0, 1'b1);
        chk("gate_one_record", 32'(evt_valid), 0);

        // Masked checker 2 never counted.
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'b0100, 4'b0100, 4'h0, 1'b0, 2'd2, 1'b0);
        idle(2'd2, 1'b0);
        chk("mask_fail_cnt2", 32'(fail_cnt_o), 0);
        chk("mask_no_evt",    32'(evt_valid),  0);

        // Same-cycle fails on 0, 2, 3: one record, two drops.
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0);
        cyc(1'b1, 4'h0, 4'b1101, 4'h0, 1'b0, 2'd3, 1'b0);
        idle(2'd3, 1'b0);
        chk("collide_drop", 32'(drop_cnt), 2);
        chk("collide_idx",  32'(evt_idx),  0);
        chk("collide_fail3", 32'(fail_cnt_o), 1);
        idle(2'd2, 1'b1);

        // Fill the FIFO with checker 3 fails, then push while full and popping.
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'h0, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b0);
        chk("full_drop",  32'(drop_cnt), 2);
        chk("full_occ",   32'(dut.u_fifo.occ_q), 8);
        cyc(1'b1, 4'h0, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b1);
        chk("full_pushpop_drop", 32'(drop_cnt), 2);
        chk("full_pushpop_occ",  32'(dut.u_fifo.occ_q), 8);

        // Saturation, then clear racing a fail.
        for (int i = 0; i < 300; i++) cyc(1'b1, 4'h0, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1);
        idle(2'd0, 1'b1);
        chk("sat_pass_cnt", 32'(pass_cnt_o), 255);
        cyc(1'b1, 4'h0, 4'b0001, 4'h0, 1'b1, 2'd0, 1'b0);
        idle(2'd0, 1'b0);
        chk("clr_fail_cnt", 32'(fail_cnt_o), 0);
        chk("clr_any_fail", 32'(any_fail),   0);
        chk("clr_evt_kept", 32'(evt_valid),  1);

        // Reset in the middle of draining.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h0, 4'b0010, 4'h0, 1'b0, 2'd1, 1'b0);
        idle(2'd1, 1'b1);
        do_reset();
        chk("midrst_evt_valid", 32'(evt_valid), 0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic       a_on, clr, rdy;
            logic [3:0] msk, v, p;
            logic [1:0] s;
            a_on = ($urandom_range(0, 9) != 0);
            msk  = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
            v    = 4'($urandom());
            p    = 4'($urandom());
            clr  = ($urandom_range(0, 63) == 0);
            s    = 2'($urandom());
            rdy  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(a_on, msk, v, p, clr, s, rdy);
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/assert_event_monitor.md
Name: assert_event_monitor

Overview:
- Consumes pass/fail strobes from the immediate-assertion checkers in a design and turns them into statistics.
- Per-checker saturating pass/fail counters, a global on/off gate and a per-checker disable mask.
- A timestamped FIFO of failure records drained by a valid/ready consumer (logger or CPU port).
- Sits directly downstream of the checker logic.

Parameters:
- N_CHK, 4, number of checker inputs (1..16)
- CW, 8, width of each counter and of drop_cnt
- TW, 16, width of the free-running timestamp
- FIFO_DEPTH, 8, failure-record FIFO depth (power of 2, >=2)
- IDXW, $clog2(N_CHK) (min 1), checker index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- assert_on  in  1  global enable; 0 = all checker events ignored
- chk_mask  in  N_CHK  per-checker disable; 1 = events of checker i ignored
- chk_valid  in  N_CHK  checker i evaluated this cycle
- chk_pass  in  N_CHK  result of checker i (1 pass, 0 fail); meaningful only with chk_valid[i]
- clr_stats  in  1  zero all counters, drop_cnt and any_fail
- sel  in  IDXW  counter readout select
- pass_cnt_o  out  CW  pass count of checker sel
- fail_cnt_o  out  CW  fail count of checker sel
- drop_cnt  out  CW  failure records lost (FIFO full or same-cycle collision)
- any_fail  out  1  sticky: a qualified fail occurred since reset/clear
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts the head record
- evt_idx  out  IDXW  checker index of the head record
- evt_time  out  TW  timestamp of the head record

Behaviour:
- Qualified event i: chk_valid[i] & assert_on & ~chk_mask[i]. Non-qualified events have no effect on any state.
- Timestamp
  - ts increments by 1 every cycle; wraps from 2^TW-1 to 0.
  - Equals 0 in the cycle after rst deasserts.
- Counters
  - Qualified pass increments pass_cnt[i]; qualified fail increments fail_cnt[i].
  - Both saturate at 2^CW-1, never wrap.
  - Multiple checkers in one cycle are each counted independently.
- Readout
  - pass_cnt_o/fail_cnt_o are registered: value reflects sel and counter state one cycle earlier.
  - sel >= N_CHK reads 0.
- any_fail is set on any qualified fail and cleared only by rst or clr_stats.
- Failure capture
  - Each cycle, the lowest-index qualified fail is the push candidate, with evt_time = current ts.
  - Every other qualified fail in the same cycle increments drop_cnt (saturating), one per extra fail.
- FIFO (first-word fall-through)
  - evt_valid = ~empty; evt_idx/evt_time show the head record.
  - Pop when evt_valid & evt_ready.
  - Push accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the candidate is dropped and drop_cnt increments.
  - Push to empty: evt_valid goes high the next cycle.
  - Head stable while evt_valid & ~evt_ready.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- clr_stats
  - Same-cycle events are not counted: clear wins for counters, drop_cnt and any_fail.
  - The FIFO push/pop of that cycle still happens; FIFO contents are not cleared.
- rst, including mid-operation: all counters, drop_cnt, ts, FIFO pointers/occupancy and readout registers go to 0. Outputs read as:
  - evt_valid=0, any_fail=0
  - pass_cnt_o=0, fail_cnt_o=0, drop_cnt=0
  - evt_idx=0, evt_time=0
  - Inputs are ignored during rst.

Decomposition:
- Package assert_mon_pkg:
  - default parameter constants
  - typedef struct packed {idx, time} fail_rec_t
  - saturating-increment function
- Sub-module assert_evt_fifo: synchronous FWFT FIFO of fail_rec_t with push/pop/full/empty, parameter FIFO_DEPTH.
- Counters, arbitration, timestamp and readout live in the top.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, evt_valid=0; ts reaches 5 internally (probe).
- assert_on=1, checker 1 fail at ts=10, pass at ts=11, sel=1 -> evt_valid at ts=11 with evt_idx=1, evt_time=10; from ts=13 (one cycle after the ts=11 pass is counted) pass_cnt_o=1, fail_cnt_o=1, any_fail=1.
- assert_on=0 for 50 cycles with checker 0 failing every cycle, then assert_on=1 with one fail -> fail_cnt[0]=1, exactly one FIFO record; repeat with chk_mask[2]=1 -> checker 2 never counted.
- Same cycle fails on checkers 0, 2, 3 -> one record evt_idx=0, drop_cnt=2, fail_cnt of each = 1.
- evt_ready=0, 10 single fails on checker 3 -> FIFO holds 8, drop_cnt=2. Then fail with evt_ready=1 while full -> push accepted, occupancy stays 8.
- 300 passes on checker 0 with CW=8 -> pass_cnt_o=255. Then clr_stats with a simultaneous fail -> counters 0, any_fail=0, FIFO record pushed. Then rst mid-drain -> evt_valid=0 next cycle.
